// File: rtl/mb_rtu_frame_timer.sv
// ---------------------------------------------------------------------------
// mb_rtu_frame_timer
//   Modbus RTU frame delimiter. Watches the UART receiver's byte strobe and
//   busy flag, times inter-character silence and decides where frames begin
//   and end. A silence of 1.5 characters inside a frame marks the frame as
//   broken if more bytes follow; a silence of 3.5 characters closes it.
//
// Ports
//   clk, rst_n    clock (rising edge), asynchronous active-low reset
//   rx_done       1-cycle strobe: a byte was received
//   rx_state      high while a character is on the wire
//   rx_new_frame  1-cycle pulse on the first byte of a frame
//   frame_end     1-cycle pulse when 3.5-char silence closes a frame
//   frame_err     frame invalid flag, qualified by frame_end
//   frame_len     byte count of the last closed frame (held)
//   byte_cnt      running byte count of the current frame
//   bus_idle      high while waiting for a new frame
// ---------------------------------------------------------------------------
module mb_rtu_frame_timer #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 115200,
    parameter int CHAR_BITS = 11,
    parameter int MAX_BYTES = 256,
    parameter int T15_OVR   = 0,
    parameter int T35_OVR   = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_done,
    input  logic       rx_state,
    output logic       rx_new_frame,
    output logic       frame_end,
    output logic       frame_err,
    output logic [8:0] frame_len,
    output logic [8:0] byte_cnt,
    output logic       bus_idle
);

    // Above 19200 baud Modbus fixes the gaps at 750 us / 1750 us; below it
    // they scale with the character time. 64-bit math: CLK_FREQ*1750 does
    // not fit in 32 bits.
    localparam longint CLK_L    = longint'(CLK_FREQ);
    localparam longint BIT_CLKS = CLK_L / longint'(BAUD_RATE);
    localparam longint CHAR_L   = longint'(CHAR_BITS);
    localparam longint T15_CALC = (BAUD_RATE > 19200) ? (CLK_L * 64'd750) / 64'd1000000
                                                      : (BIT_CLKS * CHAR_L * 64'd3) / 64'd2;
    localparam longint T35_CALC = (BAUD_RATE > 19200) ? (CLK_L * 64'd1750) / 64'd1000000
                                                      : (BIT_CLKS * CHAR_L * 64'd7) / 64'd2;
    localparam int T15 = (T15_OVR != 0) ? T15_OVR : int'(T15_CALC);
    localparam int T35 = (T35_OVR != 0) ? T35_OVR : int'(T35_CALC);
    localparam int CW  = $clog2(T35 + 1);

    localparam logic [CW-1:0] T15_C = CW'(T15);
    localparam logic [CW-1:0] T35_C = CW'(T35);
    localparam logic [8:0]    MAX_C = 9'(MAX_BYTES);

    typedef enum logic [1:0] {INIT, IDLE, RECV, GAP} state_t;

    state_t        state, state_n;
    logic [CW-1:0] sil, sil_n;
    logic          err, err_n;
    logic [8:0]    cnt_n, flen_n;
    logic          nf_n, fe_n, ferr_n;
    logic          hit15, hit35;

    // Silence counter; thresholds are judged on the value it takes at this
    // edge, so a byte arriving in the same cycle (counter cleared) always
    // wins over a timeout. T15 < T35 guarantees RECV passes through GAP.
    always_comb begin
        if (rx_done || rx_state) sil_n = '0;
        else if (sil == T35_C)   sil_n = sil;
        else                     sil_n = sil + 1'b1;
    end

    assign hit15 = !rx_done && (sil_n == T15_C);
    assign hit35 = !rx_done && (sil_n == T35_C);

    always_comb begin
        state_n = state;
        cnt_n   = byte_cnt;
        err_n   = err;
        nf_n    = 1'b0;
        fe_n    = 1'b0;
        ferr_n  = frame_err;
        flen_n  = frame_len;
        case (state)
            INIT: if (hit35) state_n = IDLE;   // bytes ignored until bus is quiet
            IDLE: if (rx_done) begin
                state_n = RECV;
                cnt_n   = 9'd1;
                err_n   = 1'b0;
                nf_n    = 1'b1;
            end
            RECV: begin
                if (rx_done) begin
                    if (byte_cnt == MAX_C) err_n = 1'b1;
                    else                   cnt_n = byte_cnt + 9'd1;
                end else if (hit15) begin
                    state_n = GAP;
                end
            end
            GAP: begin
                if (rx_done) begin
                    // a byte after a 1.5-char gap breaks the frame
                    state_n = RECV;
                    err_n   = 1'b1;
                    if (byte_cnt != MAX_C) cnt_n = byte_cnt + 9'd1;
                end else if (hit35) begin
                    state_n = IDLE;
                    fe_n    = 1'b1;
                    flen_n  = byte_cnt;
                    ferr_n  = err;
                end
            end
            default: state_n = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= INIT;
            sil          <= '0;
            err          <= 1'b0;
            byte_cnt     <= '0;
            rx_new_frame <= 1'b0;
            frame_end    <= 1'b0;
            frame_err    <= 1'b0;
            frame_len    <= '0;
            bus_idle     <= 1'b0;
        end else begin
            state        <= state_n;
            sil          <= sil_n;
            err          <= err_n;
            byte_cnt     <= cnt_n;
            rx_new_frame <= nf_n;
            frame_end    <= fe_n;
            frame_err    <= ferr_n;
            frame_len    <= flen_n;
            bus_idle     <= (state_n == IDLE);
        end
    end

endmodule

// File: tb/tb_mb_rtu_frame_timer.sv
// ---------------------------------------------------------------------------
// tb_mb_rtu_frame_timer
//   Two small-timeout instances (T15=15, T35=35; MAX_BYTES 8 and 3) share
//   stimulus and are compared every cycle against a reference model that
//   reasons in "silent cycles since last activity". Two more instances use
//   computed timeouts (fast-baud and slow-baud formulas).
// ---------------------------------------------------------------------------
module tb_mb_rtu_frame_timer;

    localparam int T15 = 15;
    localparam int T35 = 35;
    int MX[2] = '{8, 3};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx_done = 1'b0;
    logic rx_state = 1'b0;
    logic       nf[2], fe[2], ferr[2], idle[2];
    logic [8:0] flen[2], bcnt[2];

    // computed-timeout instances: A 2 MHz/115200 -> 1500/3500,
    // B 1 MHz/9600 -> 104*11*3/2 = 1716, 104*11*7/2 = 4004
    logic aux_rst_n = 1'b0;
    logic aux_done = 1'b0;
    logic a_nf, a_fe, a_ferr, a_idle, b_nf, b_fe, b_ferr, b_idle;
    logic [8:0] a_flen, a_bcnt, b_flen, b_bcnt;

    always #5 clk = ~clk;

    mb_rtu_frame_timer #(.MAX_BYTES(8), .T15_OVR(T15), .T35_OVR(T35)) dut0 (
        .clk(clk), .rst_n(rst_n), .rx_done(rx_done), .rx_state(rx_state),
        .rx_new_frame(nf[0]), .frame_end(fe[0]), .frame_err(ferr[0]),
        .frame_len(flen[0]), .byte_cnt(bcnt[0]), .bus_idle(idle[0]));

    mb_rtu_frame_timer #(.MAX_BYTES(3), .T15_OVR(T15), .T35_OVR(T35)) dut1 (
        .clk(clk), .rst_n(rst_n), .rx_done(rx_done), .rx_state(rx_state),
        .rx_new_frame(nf[1]), .frame_end(fe[1]), .frame_err(ferr[1]),
        .frame_len(flen[1]), .byte_cnt(bcnt[1]), .bus_idle(idle[1]));

    mb_rtu_frame_timer #(.CLK_FREQ(2000000), .BAUD_RATE(115200)) dut_a (
        .clk(clk), .rst_n(aux_rst_n), .rx_done(aux_done), .rx_state(1'b0),
        .rx_new_frame(a_nf), .frame_end(a_fe), .frame_err(a_ferr),
        .frame_len(a_flen), .byte_cnt(a_bcnt), .bus_idle(a_idle));

    mb_rtu_frame_timer #(.CLK_FREQ(1000000), .BAUD_RATE(9600)) dut_b (
        .clk(clk), .rst_n(aux_rst_n), .rx_done(aux_done), .rx_state(1'b0),
        .rx_new_frame(b_nf), .frame_end(b_fe), .frame_err(b_ferr),
        .frame_len(b_flen), .byte_cnt(b_bcnt), .bus_idle(b_idle));

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference model: state is "still waiting for first quiet period",
    // "frame open", "a 1.5-char silence happened since the last byte",
    // and the number of silent cycles since the last activity.
    bit m_init, m_open, m_late;
    int m_sil;
    int m_cnt[2], m_len[2];
    bit m_err[2], m_ferr[2];
    bit e_nf, e_fe;

    task automatic model_reset();
        m_init = 1; m_open = 0; m_late = 0; m_sil = 0; e_nf = 0; e_fe = 0;
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0; m_len[k] = 0; m_err[k] = 0; m_ferr[k] = 0;
        end
    endtask

    task automatic model_step(input bit d, input bit s);
        e_nf = 0; e_fe = 0;
        if (d || s) begin
            if (d && !m_init) begin
                if (!m_open) begin
                    m_open = 1; e_nf = 1;
                    for (int k = 0; k < 2; k++) begin m_cnt[k] = 1; m_err[k] = 0; end
                end else begin
                    for (int k = 0; k < 2; k++) begin
                        if (m_late) m_err[k] = 1;
                        if (m_cnt[k] == MX[k]) m_err[k] = 1;
                        else m_cnt[k]++;
                    end
                end
                m_late = 0;
            end
            m_sil = 0;
        end else begin
            m_sil++;
            if (m_open && m_sil == T15) m_late = 1;
            if (m_sil == T35) begin
                if (m_init) m_init = 0;
                else if (m_open) begin
                    m_open = 0; e_fe = 1;
                    for (int k = 0; k < 2; k++) begin m_len[k] = m_cnt[k]; m_ferr[k] = m_err[k]; end
                end
            end
        end
    endtask

    task automatic check_outputs();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("new_frame[%0d]", k), nf[k], e_nf);
            chk($sformatf("frame_end[%0d]", k), fe[k], e_fe);
            chk($sformatf("bus_idle[%0d]", k), idle[k], !m_init && !m_open);
            chk($sformatf("byte_cnt[%0d]", k), bcnt[k], m_cnt[k]);
            chk($sformatf("frame_len[%0d]", k), flen[k], m_len[k]);
            if (e_fe) chk($sformatf("frame_err[%0d]", k), ferr[k], m_ferr[k]);
        end
    endtask

    // called at a falling edge; drives one cycle and checks the result
    task automatic step(input bit d, input bit s);
        rx_done = d; rx_state = s;
        @(posedge clk);
        model_step(d, s);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic send_byte(input int gap);
        repeat (gap) step(0, 0);
        step(1, 0);
    endtask

    task automatic do_reset();
        rst_n = 0; rx_done = 0; rx_state = 0;
        #2;
        for (int k = 0; k < 2; k++) begin
            chk("rst_new_frame", nf[k], 0);
            chk("rst_frame_end", fe[k], 0);
            chk("rst_frame_err", ferr[k], 0);
            chk("rst_frame_len", flen[k], 0);
            chk("rst_byte_cnt", bcnt[k], 0);
            chk("rst_bus_idle", idle[k], 0);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic aux_pulse();
        aux_done = 1;
        @(negedge clk);
        aux_done = 0;
    endtask

    initial begin
        int ka, kb, gap, a_err_seen;
        bit busy;
        model_reset();
        @(negedge clk);

        // quiet bus: idle exactly 35 clocks after release
        do_reset();
        repeat (T35 - 1) step(0, 0);
        chk("idle_early", idle[0], 0);
        step(0, 0);
        chk("idle_at_35", idle[0], 1);

        // byte during INIT is ignored and restarts the quiet period
        do_reset();
        repeat (19) step(0, 0);
        step(1, 0);
        repeat (T35 - 1) step(0, 0);
        chk("init_byte_idle_early", idle[0], 0);
        chk("init_byte_no_count", bcnt[0], 0);
        step(0, 0);
        chk("init_byte_idle_35", idle[0], 1);

        // four bytes 10 clocks apart
        send_byte(3);
        chk("first_new_frame", nf[0], 1);
        chk("first_cnt", bcnt[0], 1);
        repeat (3) send_byte(9);
        chk("cnt_4", bcnt[0], 4);
        repeat (T35) step(0, 0);
        chk("good_frame_end", fe[0], 1);
        chk("good_len", flen[0], 4);
        chk("good_err", ferr[0], 0);

        // third byte after a 20-clock gap
        send_byte(5); send_byte(9); send_byte(19); send_byte(9);
        repeat (T35) step(0, 0);
        chk("gap_len", flen[0], 4);
        chk("gap_err", ferr[0], 1);

        // five bytes: MAX_BYTES=3 instance saturates
        send_byte(2);
        repeat (4) send_byte(9);
        chk("sat_cnt", bcnt[1], 3);
        repeat (T35) step(0, 0);
        chk("sat_len", flen[1], 3);
        chk("sat_err", ferr[1], 1);
        chk("nosat_len", flen[0], 5);
        chk("nosat_err", ferr[0], 0);

        // byte on the very cycle silence would reach 35
        send_byte(2);
        send_byte(T35 - 1);
        chk("tie_no_end", fe[0], 0);
        repeat (T35) step(0, 0);
        chk("tie_len", flen[0], 2);
        chk("tie_err", ferr[0], 1);

        // reset mid-frame discards the frame
        send_byte(2); send_byte(5);
        do_reset();
        repeat (T35 + 10) step(0, 0);
        chk("rst_mid_len", flen[0], 0);

        // randomized traffic
        for (int i = 0; i < 250; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 5)      gap = $urandom_range(0, 12);
            else if (r < 8) gap = $urandom_range(13, 17);
            else            gap = $urandom_range(30, 40);
            busy = ($urandom_range(0, 3) == 0);
            for (int j = 0; j < gap; j++)
                step(0, busy && ($urandom_range(0, 7) == 0));
            step(1, $urandom_range(0, 1));
            if ($urandom_range(0, 59) == 0) do_reset();
        end
        repeat (T35 + 2) step(0, 0);

        // computed timeouts
        @(negedge clk);
        aux_rst_n = 1;
        ka = 0; kb = 0;
        for (int k = 1; k <= 5000 && (ka == 0 || kb == 0); k++) begin
            @(negedge clk);
            if (a_idle && ka == 0) ka = k;
            if (b_idle && kb == 0) kb = k;
        end
        chk("fast_baud_t35", ka, 3500);
        chk("slow_baud_t35", kb, 4004);

        // slow baud: 1715 silent cycles is still inside 1.5 chars
        aux_pulse();
        repeat (1715) @(negedge clk);
        aux_pulse();
        kb = 0;
        for (int k = 1; k <= 5000 && kb == 0; k++) begin
            @(negedge clk);
            if (b_fe) begin
                kb = k;
                chk("slow_ok_len", b_flen, 2);
                chk("slow_ok_err", b_ferr, 0);
            end
        end
        chk("slow_end_time", kb, 4004);

        // 1716 silent cycles reaches 1.5 chars
        aux_pulse();
        repeat (1716) @(negedge clk);
        aux_pulse();
        kb = 0; a_err_seen = -1;
        for (int k = 1; k <= 5000 && kb == 0; k++) begin
            @(negedge clk);
            if (a_fe) a_err_seen = a_ferr;
            if (b_fe) begin
                kb = k;
                chk("slow_late_err", b_ferr, 1);
            end
        end
        chk("slow_late_end_time", kb, 4004);
        chk("fast_late_err", a_err_seen, 1);
        chk("fast_len", a_flen, 2);
        chk("fast_cnt_hold", a_bcnt, 2);
        chk("fast_idle", a_idle, 1);
        chk("fast_no_pulse", a_nf | a_fe, 0);
        chk("slow_cnt_hold", b_bcnt, 2);
        chk("slow_no_pulse", b_nf | b_idle, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mb_rtu_frame_timer.md
MB_RTU_FRAME_TIMER -- requirements
Module: mb_rtu_frame_timer

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115200, UART baud rate.
REQ-003 Parameter CHAR_BITS, default 11, bits per character (start + 8 data + parity/stop + stop).
REQ-004 Parameter MAX_BYTES, default 256, maximum legal frame length in bytes.
REQ-005 Parameter T15_OVR, default 0, 1.5-char timeout in clocks; 0 selects the computed value.
REQ-006 Parameter T35_OVR, default 0, 3.5-char timeout in clocks; 0 selects the computed value.
REQ-007 clk  input  1  system clock; all logic on rising edge.
REQ-008 rst_n  input  1  asynchronous active-low reset.
REQ-009 rx_done  input  1  one-cycle pulse, a byte has been received.
REQ-010 rx_state  input  1  high while a character is being received.
REQ-011 rx_new_frame  output  1  one-cycle pulse on the first byte of a frame.
REQ-012 frame_end  output  1  one-cycle pulse when 3.5-char silence closes a frame.
REQ-013 frame_err  output  1  valid only with frame_end; 1 = frame is invalid.
REQ-014 frame_len  output  9  byte count of the closed frame, valid with frame_end, held until the next frame_end.
REQ-015 byte_cnt  output  9  running byte count of the current frame.
REQ-016 bus_idle  output  1  high while in IDLE.

Function
REQ-017 Timeouts: T15_OVR/T35_OVR nonzero -> used as given; otherwise BAUD_RATE > 19200 -> T15 = CLK_FREQ*750/1e6, T35 = CLK_FREQ*1750/1e6; else T15 = (CLK_FREQ/BAUD_RATE)*CHAR_BITS*3/2, T35 = (CLK_FREQ/BAUD_RATE)*CHAR_BITS*7/2 (integer arithmetic).
REQ-018 Defaults give T15 = 37500 and T35 = 87500 clocks; the silence counter width shall be clog2(T35+1).
REQ-019 Silence counter: cleared to 0 in any cycle with rx_state=1 or rx_done=1; otherwise +1 per clock, saturating at T35.
REQ-020 States: INIT, IDLE, RECV, GAP.
REQ-021 INIT (after reset): rx_done is ignored (no pulses, no count); counter == T35 -> IDLE.
REQ-022 IDLE: rx_done -> rx_new_frame=1 the same cycle as registered output (cycle after rx_done), byte_cnt=1, error flag cleared, -> RECV.
REQ-023 RECV: rx_done -> byte_cnt+1; counter == T15 with no rx_done -> GAP.
REQ-024 GAP: rx_done -> error flag set, byte_cnt+1, -> RECV; counter == T35 with no rx_done -> frame_end pulse, frame_len=byte_cnt, frame_err=error flag, -> IDLE.
REQ-025 The counter shall reach T15 before reaching T35, so RECV always passes through GAP.
REQ-026 Overflow: rx_done with byte_cnt == MAX_BYTES -> byte_cnt holds at MAX_BYTES and the error flag is set.
REQ-027 Simultaneous rx_done with a threshold hit: rx_done has priority; no state timeout occurs that cycle.
REQ-028 All outputs are registered; pulses are exactly one clock wide; latency from the causing event is one clock.
REQ-029 byte_cnt holds its last value in IDLE until the next rx_new_frame.

Reset
REQ-030 rst_n low asynchronously forces state=INIT, counter=0, error flag=0, and rx_new_frame, frame_end, frame_err, frame_len, byte_cnt, bus_idle = 0.
REQ-031 Reset asserted mid-frame discards that frame: no frame_end is issued, and INIT silence is required again.

Verification (T15_OVR=15, T35_OVR=35 unless stated)
REQ-032 Release reset, bus silent -> bus_idle=1 exactly 35 clocks after release; rx_done at clock 20 after release -> ignored, idle delayed to 35 clocks after that rx_done.
REQ-033 From IDLE, 4 rx_done pulses spaced 10 clocks apart -> one rx_new_frame on the first, byte_cnt 1..4, frame_end 35 clocks after the last, frame_len=4, frame_err=0.
REQ-034 Same frame, but the third byte arrives 20 clocks after the second -> frame_end with frame_len=4, frame_err=1.
REQ-035 MAX_BYTES=3, 5 bytes in one frame -> byte_cnt saturates at 3, frame_len=3, frame_err=1.
REQ-036 rx_done in the same cycle the counter reaches 35 in GAP -> no frame_end, frame_err=1 at the eventual close; rst_n pulsed mid-frame -> all outputs 0, no frame_end.
REQ-037 Default parameters (115200 baud) -> T15=37500, T35=87500; 9600 baud -> T15=85932, T35=200508 (5208*11*3/2, 5208*11*7/2).
